// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector.
//
// Contents:
//   DEFAULT_LEN / DEFAULT_PAT : pattern length and pattern used after reset
//   len_w()                   : width needed to hold a length 0..max_len
//   ovl_mode_e                : overlapping / non-overlapping detection mode
package seq_det_pkg;

  // Power-up pattern: three zeros, right-aligned in up to 32 bits.
  localparam int          DEFAULT_LEN = 3;
  localparam logic [31:0] DEFAULT_PAT = 32'b000;

  // Width of a field that must hold every value 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear.
//
// Ports:
//   clk   in  : rising-edge clock
//   reset in  : asynchronous active-low reset (count -> 0)
//   clr   in  : synchronous clear, takes priority over inc
//   inc   in  : count up by one unless already at MAX
//   q     out : current count (W bits)
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear beats increment so a clear cycle always leaves the count at zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector.
//
// A pattern of 1..MAX_LEN bits is compared against the most recent accepted
// serial bits. The first-received pattern bit lives at pat[len-1], the last
// at pat[0]. Detection can be overlapping or non-overlapping.
//
// Ports:
//   clk        in  : rising-edge clock
//   reset      in  : asynchronous active-low reset
//   xin        in  : serial data bit
//   xin_valid  in  : xin is consumed this cycle
//   pat_load   in  : load pat_in/len_in (xin is discarded this cycle)
//   pat_in     in  : new pattern, right-aligned
//   len_in     in  : new pattern length (legal 1..MAX_LEN)
//   overlap    in  : 1 = overlapping detection, 0 = non-overlapping
//   cnt_clr    in  : synchronous clear of match_cnt (wins over a match)
//   y          out : combinational match on the final pattern bit
//   y_q        out : y delayed by one cycle
//   match_cnt  out : saturating number of matches
//   cfg_err    out : one-cycle pulse after an illegal load
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter int                 DEF_LEN = DEFAULT_LEN,
  parameter logic [MAX_LEN-1:0] DEF_PAT = DEFAULT_PAT[MAX_LEN-1:0],
  localparam int                LW      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               xin,
  input  logic               xin_valid,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LW-1:0]      len_in,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic               y_q,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               cfg_err_q, cfg_err_d;
  logic               y_d;

  logic [LW-1:0]      fill_q;
  logic               fill_clr;

  logic               accept;
  logic               len_legal;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;
  logic               pattern_hit;

  // A load cycle always swallows the data bit, legal load or not.
  assign accept    = xin_valid & ~pat_load;
  assign len_legal = (len_in != '0) && (len_in <= LW'(MAX_LEN));

  // The window includes the bit arriving right now, which is what makes y Mealy.
  assign win = {hist_q[MAX_LEN-2:0], xin};

  // Only the low len bits of window and pattern take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len_q);
    end
  end

  // fill counts the history bits behind the current one; len-1 of them are
  // needed. Widened by one bit so fill+1 cannot wrap for any MAX_LEN.
  assign fill_ok     = ({1'b0, fill_q} + (LW+1)'(1)) >= {1'b0, len_q};
  assign pattern_hit = ((win ^ pat_q) & mask) == '0;

  // Gating with reset keeps y low while the block is held in reset, even for
  // a one-bit default pattern.
  assign y_d = accept & fill_ok & pattern_hit & reset;
  assign y   = y_d;

  // Non-overlapping mode restarts the fill after a match so the next match
  // needs a full set of fresh bits; a legal load restarts it as well.
  assign fill_clr = (pat_load & len_legal) |
                    (y_d & (ovl_mode_e'(overlap) == OVL_OFF));

  // Next-state for history and configuration. Illegal loads leave every piece
  // of state alone and only raise cfg_err for the following cycle.
  always_comb begin
    hist_d    = hist_q;
    pat_d     = pat_q;
    len_d     = len_q;
    cfg_err_d = 1'b0;
    if (pat_load) begin
      if (len_legal) begin
        pat_d  = pat_in;
        len_d  = len_in;
        hist_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (xin_valid) begin
      hist_d = win;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q    <= '0;
      pat_q     <= DEF_PAT;
      len_q     <= LW'(DEF_LEN);
      cfg_err_q <= 1'b0;
      y_q       <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      cfg_err_q <= cfg_err_d;
      y_q       <= y_d;
    end
  end

  assign cfg_err = cfg_err_q;

  // Number of accepted bits since the last restart, capped at MAX_LEN.
  sat_counter #(
    .W   (LW),
    .MAX (LW'(MAX_LEN))
  ) u_fill (
    .clk   (clk),
    .reset (reset),
    .clr   (fill_clr),
    .inc   (accept),
    .q     (fill_q)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (y_d),
    .q     (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomised and directed bench for seq_detect_prog against a queue-based
// reference model of the detector's rules.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LW      = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               xin = 1'b0;
  logic               xin_valid = 1'b0;
  logic               pat_load = 1'b0;
  logic [MAX_LEN-1:0] pat_in = '0;
  logic [LW-1:0]      len_in = '0;
  logic               overlap = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               y;
  logic               y_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  seq_detect_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .xin       (xin),
    .xin_valid (xin_valid),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .overlap   (overlap),
    .cnt_clr   (cnt_clr),
    .y         (y),
    .y_q       (y_q),
    .match_cnt (match_cnt),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int numChecks = 0;
  int numErrors = 0;

  // Reference model: accepted bits since the last restart, oldest first.
  bit                 bits_q[$];
  logic [MAX_LEN-1:0] mpat;
  int                 mlen;
  int                 mcount;
  bit                 exp_err;
  bit                 exp_yq;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // The last mlen bits (history plus the incoming bit) must equal the pattern
  // read from pat[mlen-1] down to pat[0].
  function automatic bit modelMatch(input bit x);
    int n;
    bit b;
    n = bits_q.size();
    if (n < mlen - 1) return 1'b0;
    for (int k = 0; k < mlen; k++) begin
      b = (k == mlen - 1) ? x : bits_q[n - (mlen - 1) + k];
      if (b != mpat[mlen - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelReset();
    bits_q.delete();
    mpat    = '0;
    mlen    = 3;
    mcount  = 0;
    exp_err = 1'b0;
    exp_yq  = 1'b0;
  endtask

  // One clock cycle: drive, check Mealy y, clock, update model, check registers.
  task automatic applyStimulus(input bit v, input bit x, input bit ld,
                               input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l,
                               input bit ovl, input bit clr);
    bit accept;
    bit ey;
    @(negedge clk);
    xin_valid = v;
    xin       = x;
    pat_load  = ld;
    pat_in    = p;
    len_in    = l;
    overlap   = ovl;
    cnt_clr   = clr;
    accept    = v && !ld;
    ey        = accept && modelMatch(x);
    #1;
    checkOutput("y", {31'b0, y}, {31'b0, ey});
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (ld) begin
      if (l >= 1 && l <= MAX_LEN) begin
        mpat = p;
        mlen = int'(l);
        bits_q.delete();
      end else begin
        exp_err = 1'b1;
      end
    end else if (v) begin
      if (ey && !ovl) begin
        bits_q.delete();
      end else begin
        bits_q.push_back(x);
        if (bits_q.size() > MAX_LEN) void'(bits_q.pop_front());
      end
    end
    if (clr) mcount = 0;
    else if (ey && mcount < CNT_MAX) mcount++;
    exp_yq = ey;
    checkOutput("y_q", {31'b0, y_q}, {31'b0, exp_yq});
    checkOutput("match_cnt", {24'b0, match_cnt}, mcount);
    checkOutput("cfg_err", {31'b0, cfg_err}, {31'b0, exp_err});
  endtask

  task automatic sendBit(input bit x, input bit ovl);
    applyStimulus(1'b1, x, 1'b0, '0, '0, ovl, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic loadPattern(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l);
    applyStimulus(1'b0, 1'b0, 1'b1, p, l, 1'b1, 1'b0);
  endtask

  // Asserts reset between clock edges and checks outputs drop immediately.
  task automatic doReset();
    @(negedge clk);
    xin_valid = 1'b0;
    pat_load  = 1'b0;
    cnt_clr   = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_y", {31'b0, y}, 32'd0);
    checkOutput("rst_y_q", {31'b0, y_q}, 32'd0);
    checkOutput("rst_match_cnt", {24'b0, match_cnt}, 32'd0);
    checkOutput("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [MAX_LEN-1:0] rp;
    logic [LW-1:0]      rl;
    int                 r;

    modelReset();
    #1;
    checkOutput("init_y_q", {31'b0, y_q}, 32'd0);
    checkOutput("init_match_cnt", {24'b0, match_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Default 000 pattern, overlapping: hits on bits 3, 4 and 5.
    for (int i = 0; i < 5; i++) sendBit(1'b0, 1'b1);
    checkOutput("dflt_ovl_cnt", {24'b0, match_cnt}, 32'd3);

    // Same stream non-overlapping, one extra zero: hits on bits 3 and 6.
    doReset();
    for (int i = 0; i < 6; i++) sendBit(1'b0, 1'b0);
    checkOutput("dflt_novl_cnt", {24'b0, match_cnt}, 32'd2);

    // Pattern 1011, stream 1,0,1,1,0,1,1 in both modes.
    loadPattern(8'b0000_1011, 4'd4);
    begin
      bit stream [7] = '{1, 0, 1, 1, 0, 1, 1};
      foreach (stream[i]) sendBit(stream[i], 1'b1);
      checkOutput("p1011_ovl_cnt", {24'b0, match_cnt}, 32'd4);
      loadPattern(8'b0000_1011, 4'd4);
      foreach (stream[i]) sendBit(stream[i], 1'b0);
      checkOutput("p1011_novl_cnt", {24'b0, match_cnt}, 32'd5);

      // Gaps of three invalid cycles between bits.
      loadPattern(8'b0000_1011, 4'd4);
      for (int i = 0; i < 4; i++) begin
        sendBit(stream[i], 1'b1);
        if (i < 3) repeat (3) idleCycle();
      end
      checkOutput("gap_cnt", {24'b0, match_cnt}, 32'd6);
    end

    // Illegal loads: configuration is kept, cfg_err pulses once each.
    loadPattern(8'hFF, 4'd0);
    idleCycle();
    loadPattern(8'hFF, 4'd9);
    idleCycle();
    sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b0); sendBit(1'b1, 1'b0);
    checkOutput("illegal_keep_cnt", {24'b0, match_cnt}, 32'd7);

    // A load cycle with a valid bit drops that bit.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'b0000_0011, 4'd2, 1'b1, 1'b0);
    sendBit(1'b1, 1'b1);
    sendBit(1'b1, 1'b1);

    // Saturation of match_cnt, then clear in the same cycle as a match.
    loadPattern(8'b0000_0001, 4'd1);
    for (int i = 0; i < 260; i++) sendBit(1'b1, 1'b1);
    checkOutput("sat_cnt", {24'b0, match_cnt}, CNT_MAX);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1);
    checkOutput("clr_wins", {24'b0, match_cnt}, 32'd0);

    // Reset after two of three pattern bits loses the partial progress.
    doReset();
    sendBit(1'b0, 1'b1);
    sendBit(1'b0, 1'b1);
    doReset();
    sendBit(1'b0, 1'b1);
    sendBit(1'b0, 1'b1);
    sendBit(1'b0, 1'b1);
    checkOutput("post_rst_cnt", {24'b0, match_cnt}, 32'd1);

    // Random traffic with occasional loads (legal and illegal) and clears.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        rp = MAX_LEN'($urandom);
        rl = (r < 2) ? LW'($urandom_range(0, 9)) : LW'($urandom_range(1, 3));
        applyStimulus(1'($urandom), 1'($urandom), 1'b1, rp, rl, 1'($urandom), 1'b0);
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'b0, '0, '0,
                      1'($urandom), $urandom_range(0, 49) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Runtime-programmable serial bit-sequence detector; parametrised successor to the team's fixed-pattern detectors.
- Pattern (1..MAX_LEN bits) and length are loaded at run time.
- Selectable overlapping or non-overlapping detection; Mealy match pulse plus registered (Moore-timed) copy; saturating match counter.
- Sits on a serial input stream next to the other sequence-detector blocks; xin is qualified by a valid strobe.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- CNT_W, 8, match-counter width.
- DEF_LEN, 3, pattern length after reset (1..MAX_LEN).
- DEF_PAT, 'b000, pattern after reset (MAX_LEN bits, right-aligned).
- LW, $clog2(MAX_LEN+1), derived width of the length fields (localparam).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- xin  in  1  serial data bit.
- xin_valid  in  1  xin is consumed this cycle when high.
- pat_load  in  1  load pat_in/len_in this cycle.
- pat_in  in  MAX_LEN  pattern; first-received bit at pat_in[len-1], last at pat_in[0].
- len_in  in  LW  pattern length.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  Mealy match: combinational, same cycle as the final pattern bit.
- y_q  out  1  y registered; one cycle later.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_err  out  1  registered one-cycle pulse on an illegal load.

Behaviour:
- Reset (async, reset==0):
  - hist=0, fill=0, pat=DEF_PAT, len=DEF_LEN.
  - y_q=0, match_cnt=0, cfg_err=0.
  - y=0 while in reset.
- State:
  - hist: MAX_LEN-bit shift register; on accepted bit, hist <= {hist[MAX_LEN-2:0], xin}.
  - fill: count of accepted bits since last reset/load/non-overlap match; saturates at MAX_LEN.
- Accepted bit: xin_valid=1 and pat_load=0. A cycle with pat_load=1 discards xin.
- Window: win = {hist[len-2:0], xin}, compared on the low len bits only.
- Length 1: window is xin alone.
- Match condition (Mealy y=1): accepted bit AND fill >= len-1 AND win[len-1:0] == pat[len-1:0].
- On match:
  - overlap=1: fill increments normally (saturating).
  - overlap=0: fill <= 0, so the next match needs len fresh bits.
- Non-match accepted bit: fill increments (saturating).
- xin_valid=0: hist, fill, y unchanged; y=0.
- y_q <= y every cycle.
- match_cnt:
  - cnt_clr=1: clears to 0; a match in the same cycle is not counted (clear wins).
  - Otherwise increments on y=1 and saturates at all-ones.
- pat_load with 1 <= len_in <= MAX_LEN: pat <= pat_in, len <= len_in, hist <= 0, fill <= 0, cfg_err <= 0.
- pat_load with len_in == 0 or len_in > MAX_LEN: config unchanged, hist/fill unchanged, cfg_err <= 1 for one cycle.
- cfg_err returns to 0 on the next cycle without an illegal load.
- Reset mid-stream: all partial progress lost; pattern reverts to DEF_PAT/DEF_LEN.
- Latency: y 0 cycles after the final bit; y_q 1 cycle; match_cnt visible 1 cycle after y.

Decomposition:
- Package seq_det_pkg:
  - Default constants DEF_LEN/DEF_PAT.
  - LEN_W width function.
  - Enum typedef for overlap mode (OVL_OFF=0, OVL_ON=1).
- Sub-module sat_counter (parameter W; inputs clk, reset, clr, inc; output q; saturating):
  - Instanced for match_cnt.
  - Reusable for fill with W=LW and max MAX_LEN; add a MAX parameter.
- Comparator and window logic stay inline.

Test Plan:
- Default after reset, overlap=1, valid bits 0,0,0,0,0 -> y=1 on bits 3, 4, 5; y_q one cycle later each; match_cnt=3.
- Same stream, overlap=0 -> y=1 on bit 3 only; a further 0 sends y=1 on bit 6; match_cnt=2.
- Load pat_in=8'b0000_1011, len_in=4; stream 1,0,1,1,0,1,1 with overlap=1 -> y on bits 4 and 7.
  - With overlap=0 -> y on bit 4 only.
- Gaps: 1011 with xin_valid=0 for 3 cycles between each bit -> single y pulse coincident with the last valid bit; y=0 in all gap cycles.
- Illegal load: len_in=0, then len_in=MAX_LEN+1 -> cfg_err one-cycle pulse each; prior pattern still detects.
  - pat_load with xin_valid=1 -> that bit is ignored (no match, fill=0).
- Saturation and reset:
  - CNT_W=2, 5 matches -> match_cnt=3; cnt_clr together with a match -> 0.
  - Assert reset after 2 of 3 pattern bits -> all outputs 0 asynchronously; after release, 3 fresh bits are needed for a match.
